bcd_score_counter: RTL

Parametrised game score counter for the team_08 game datapath. It holds a saturating score in binary and in registered packed BCD. A free-running in-block tick divider rewards survival time. Rising edges of collision_detect subtract a penalty. The game-state input sets load, run, freeze and win-display behaviour. The counter sits between the collision/FSM logic and the seven-segment display driver, and its at_zero flag feeds the FSM as a game-over request.

---
 rtl/bcd_score_counter.sv | 119 +++++++++++
 1 files changed

// File: rtl/bcd_score_counter.sv
// Saturating game score with registered packed-BCD mirror, survival-tick divider
// and collision-edge penalty, steered by the game-state input.
module bcd_score_counter #(
   parameter  int DIGITS      = 2,
   parameter  int TICK_CYCLES = 60000000,
   parameter  int START_SCORE = 10,
   parameter  int MAX_SCORE   = 99,
   parameter  int INC         = 1,
   parameter  int PENALTY     = 1,
   localparam int SCORE_W     = $clog2(10**DIGITS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            state,
   input  logic                  collision_detect,
   output logic [SCORE_W-1:0]    score,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  at_max,
   output logic                  at_zero,
   output logic                  tick
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_WIN = 2'd2, ST_OVER = 2'd3} gameState_t;

   localparam int DIV_W = $clog2(TICK_CYCLES);
   localparam int SW2   = SCORE_W + 2;

   function automatic logic [4*DIGITS-1:0] toBcd(input logic [SCORE_W-1:0] value);
      logic [4*DIGITS+SCORE_W-1:0] dd;
      dd = '0;
      dd[SCORE_W-1:0] = value;
      for (int i = 0; i < SCORE_W; i++) begin
         for (int d = 0; d < DIGITS; d++) begin
            if (dd[SCORE_W+4*d +: 4] >= 4'd5)
               dd[SCORE_W+4*d +: 4] = dd[SCORE_W+4*d +: 4] + 4'd3;
         end
         dd = dd << 1;
      end
      return dd[SCORE_W +: 4*DIGITS];
   endfunction

   localparam logic [SCORE_W-1:0]    START_VAL = SCORE_W'(START_SCORE);
   localparam logic [SCORE_W-1:0]    MAX_VAL   = SCORE_W'(MAX_SCORE);
   localparam logic [4*DIGITS-1:0]   START_BCD = toBcd(START_VAL);
   localparam logic [4*DIGITS-1:0]   ALL_NINES = {DIGITS{4'h9}};
   localparam logic signed [SW2-1:0] INC_S     = SW2'(INC);
   localparam logic signed [SW2-1:0] PEN_S     = SW2'(PENALTY);
   localparam logic signed [SW2-1:0] MAX_S     = SW2'(MAX_SCORE);

   gameState_t             w_state;
   logic                   w_edge;
   logic                   w_applyTick;
   logic signed [SW2-1:0]  w_sum;
   logic [SCORE_W-1:0]     w_nextScore;
   logic [4*DIGITS-1:0]    w_bcdNext;

   logic                   r_colQ;
   logic [DIV_W-1:0]       r_divCnt;
   logic [SCORE_W-1:0]     r_score;
   logic [4*DIGITS-1:0]    r_bcd;
   logic                   r_atMax;
   logic                   r_atZero;
   logic                   r_tick;

   assign w_state = gameState_t'(state);

   // Tick and penalty are summed before a single clamp so coincident events net out.
   always_comb begin
      w_edge      = collision_detect & ~r_colQ;
      w_applyTick = (w_state == ST_RUN) && (r_divCnt == DIV_W'(TICK_CYCLES - 1));
      w_sum       = $signed({2'b00, r_score})
                    + (w_applyTick ? INC_S : '0)
                    - (w_edge ? PEN_S : '0);
      w_nextScore = r_score;
      case (w_state)
         ST_IDLE: w_nextScore = START_VAL;
         ST_RUN: begin
            if (w_sum[SW2-1])
               w_nextScore = '0;
            else if (w_sum > MAX_S)
               w_nextScore = MAX_VAL;
            else
               w_nextScore = w_sum[SCORE_W-1:0];
         end
         default: w_nextScore = r_score;
      endcase
      w_bcdNext = toBcd(w_nextScore);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_colQ   <= 1'b0;
         r_divCnt <= '0;
         r_score  <= START_VAL;
         r_bcd    <= START_BCD;
         r_atMax  <= (START_VAL == MAX_VAL);
         r_atZero <= (START_VAL == '0);
         r_tick   <= 1'b0;
      end else begin
         r_colQ   <= collision_detect;
         r_tick   <= w_applyTick;
         if (w_state == ST_RUN)
            r_divCnt <= w_applyTick ? '0 : r_divCnt + DIV_W'(1);
         else
            r_divCnt <= '0;
         r_score  <= w_nextScore;
         r_bcd    <= (w_state == ST_WIN) ? ALL_NINES : w_bcdNext;
         r_atMax  <= (w_nextScore == MAX_VAL);
         r_atZero <= (w_nextScore == '0);
      end
   end

   assign score   = r_score;
   assign bcd     = r_bcd;
   assign at_max  = r_atMax;
   assign at_zero = r_atZero;
   assign tick    = r_tick;

endmodule
